// File: rtl/axi_wr_2_arbiter.sv
// Two-master to one-slave AXI write arbiter: round-robin AW into a registered stage,
// W steered burst by burst from an order FIFO, B routed back by the ID MSB.
module axi_wr_2_arbiter #(
  parameter int IDWID  = 4,
  parameter int DWID   = 64,
  parameter int WSTRB  = DWID / 8,
  parameter int EXTRAS = 8,
  parameter int MAXOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDWID-2:0]  m0_awid,
  input  logic [31:0]       m0_awaddr,
  input  logic [7:0]        m0_awlen,
  input  logic [1:0]        m0_awburst,
  input  logic [EXTRAS-1:0] m0_awextras,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DWID-1:0]   m0_wdata,
  input  logic [WSTRB-1:0]  m0_wstrb,
  input  logic              m0_wlast,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic [IDWID-2:0]  m0_bid,
  output logic [1:0]        m0_bresp,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  input  logic [IDWID-2:0]  m1_awid,
  input  logic [31:0]       m1_awaddr,
  input  logic [7:0]        m1_awlen,
  input  logic [1:0]        m1_awburst,
  input  logic [EXTRAS-1:0] m1_awextras,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DWID-1:0]   m1_wdata,
  input  logic [WSTRB-1:0]  m1_wstrb,
  input  logic              m1_wlast,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [IDWID-2:0]  m1_bid,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [IDWID-1:0]  awid,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [1:0]        awburst,
  output logic [EXTRAS-1:0] awextras,
  output logic              awvalid,
  input  logic              awready,
  output logic [DWID-1:0]   wdata,
  output logic [WSTRB-1:0]  wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [IDWID-1:0]  bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [7:0] MAX_CNT = 8'(MAXOUT);

  logic            rr;
  logic [1:0][7:0] out_cnt;
  logic            elig0, elig1, gnt_any, gnt_sel, load_ok, fire, pop;
  logic [1:0]      inc, dec;
  logic [7:0]      order_mem;
  logic [2:0]      wr_ptr, rd_ptr;
  logic [3:0]      order_cnt;
  logic            order_full, order_empty, head, bsrc;

  assign order_full  = (order_cnt == 4'd8);
  assign order_empty = (order_cnt == 4'd0);
  assign head        = order_mem[rd_ptr];

  // A full order FIFO blocks grants even when a pop happens in the same cycle.
  assign load_ok = (!awvalid || awready) && !order_full;
  assign elig0   = m0_awvalid && (out_cnt[0] != MAX_CNT);
  assign elig1   = m1_awvalid && (out_cnt[1] != MAX_CNT);
  assign gnt_any = elig0 || elig1;
  assign gnt_sel = (elig0 && elig1) ? rr : elig1;
  assign fire    = load_ok && gnt_any;

  assign m0_awready = fire && !gnt_sel;
  assign m1_awready = fire && gnt_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awid     <= '0;
      awaddr   <= '0;
      awlen    <= '0;
      awburst  <= '0;
      awextras <= '0;
      awvalid  <= 1'b0;
      rr       <= 1'b0;
    end else if (fire) begin
      awid     <= gnt_sel ? {1'b1, m1_awid} : {1'b0, m0_awid};
      awaddr   <= gnt_sel ? m1_awaddr   : m0_awaddr;
      awlen    <= gnt_sel ? m1_awlen    : m0_awlen;
      awburst  <= gnt_sel ? m1_awburst  : m0_awburst;
      awextras <= gnt_sel ? m1_awextras : m0_awextras;
      awvalid  <= 1'b1;
      rr       <= ~gnt_sel;
    end else if (awready) begin
      awvalid  <= 1'b0;
    end
  end

  assign pop = wvalid && wready && wlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_mem <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      order_cnt <= '0;
    end else begin
      if (fire) begin
        order_mem[wr_ptr] <= gnt_sel;
        wr_ptr            <= wr_ptr + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 3'd1;
      case ({fire, pop})
        2'b10:   order_cnt <= order_cnt + 4'd1;
        2'b01:   order_cnt <= order_cnt - 4'd1;
        default: order_cnt <= order_cnt;
      endcase
    end
  end

  always_comb begin
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    m0_wready = 1'b0;
    m1_wready = 1'b0;
    if (!order_empty) begin
      if (head) begin
        wvalid    = m1_wvalid;
        wdata     = m1_wdata;
        wstrb     = m1_wstrb;
        wlast     = m1_wlast;
        m1_wready = wready;
      end else begin
        wvalid    = m0_wvalid;
        wdata     = m0_wdata;
        wstrb     = m0_wstrb;
        wlast     = m0_wlast;
        m0_wready = wready;
      end
    end
  end

  assign bsrc = bid[IDWID-1];

  always_comb begin
    m0_bvalid = 1'b0;
    m0_bid    = '0;
    m0_bresp  = '0;
    m1_bvalid = 1'b0;
    m1_bid    = '0;
    m1_bresp  = '0;
    if (bsrc) begin
      m1_bvalid = bvalid;
      m1_bid    = bid[IDWID-2:0];
      m1_bresp  = bresp;
      bready    = m1_bready;
    end else begin
      m0_bvalid = bvalid;
      m0_bid    = bid[IDWID-2:0];
      m0_bresp  = bresp;
      bready    = m0_bready;
    end
  end

  // A response for a master with nothing outstanding is ignored by its counter.
  assign inc = {m1_awready, m0_awready};
  assign dec = {m1_bvalid && m1_bready && (out_cnt[1] != 8'd0),
                m0_bvalid && m0_bready && (out_cnt[0] != 8'd0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (inc[n] && !dec[n])      out_cnt[n] <= out_cnt[n] + 8'd1;
        else if (dec[n] && !inc[n]) out_cnt[n] <= out_cnt[n] - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_2_arbiter.sv
// Bench for axi_wr_2_arbiter: B routing vector table plus directed multi-cycle sequences.
module tb_axi_wr_2_arbiter;
  localparam int IDWID = 4, DWID = 16, WSTRB = 2, EXTRAS = 8, MAXOUT = 5;

  logic clk, rst_n;
  logic [IDWID-2:0] m0_awid, m1_awid, m0_bid, m1_bid;
  logic [31:0] m0_awaddr, m1_awaddr, awaddr;
  logic [7:0] m0_awlen, m1_awlen, awlen;
  logic [1:0] m0_awburst, m1_awburst, awburst, m0_bresp, m1_bresp, bresp;
  logic [EXTRAS-1:0] m0_awextras, m1_awextras, awextras;
  logic m0_awvalid, m0_awready, m1_awvalid, m1_awready;
  logic [DWID-1:0] m0_wdata, m1_wdata, wdata;
  logic [WSTRB-1:0] m0_wstrb, m1_wstrb, wstrb;
  logic m0_wlast, m0_wvalid, m0_wready, m1_wlast, m1_wvalid, m1_wready;
  logic m0_bvalid, m0_bready, m1_bvalid, m1_bready;
  logic [IDWID-1:0] awid, bid;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int failures = 0;
  logic [DWID-1:0] exp_q[$];

  axi_wr_2_arbiter #(.IDWID(IDWID), .DWID(DWID), .WSTRB(WSTRB), .EXTRAS(EXTRAS), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awburst(m0_awburst),
    .m0_awextras(m0_awextras), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
    .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready),
    .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awburst(m1_awburst),
    .m1_awextras(m1_awextras), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awextras(awextras),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, m0_bready, m1_bready;
    logic [12:0] exp;  // {m0_bvalid, m0_bid, m0_bresp, m1_bvalid, m1_bid, m1_bresp, bready}
  } bvec_t;
  bvec_t bvecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m0_awid = '0; m0_awaddr = '0; m0_awlen = '0; m0_awburst = '0; m0_awextras = '0; m0_awvalid = 0;
    m1_awid = '0; m1_awaddr = '0; m1_awlen = '0; m1_awburst = '0; m1_awextras = '0; m1_awvalid = 0;
    m0_wdata = '0; m0_wstrb = '0; m0_wlast = 0; m0_wvalid = 0; m0_bready = 0;
    m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_wvalid = 0; m1_bready = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beat0, grants;
    logic hs0, hs1;

    bvecs[0] = '{4'b0101, 2'd1, 1'b1, 1'b1, 1'b0, {1'b1, 3'd5, 2'd1, 1'b0, 3'd0, 2'd0, 1'b1}};
    bvecs[1] = '{4'b1110, 2'd3, 1'b1, 1'b1, 1'b0, {1'b0, 3'd0, 2'd0, 1'b1, 3'd6, 2'd3, 1'b0}};
    bvecs[2] = '{4'b1110, 2'd3, 1'b1, 1'b0, 1'b1, {1'b0, 3'd0, 2'd0, 1'b1, 3'd6, 2'd3, 1'b1}};
    bvecs[3] = '{4'b0010, 2'd2, 1'b0, 1'b0, 1'b1, {1'b0, 3'd2, 2'd2, 1'b0, 3'd0, 2'd0, 1'b0}};
    bvecs[4] = '{4'b1000, 2'd0, 1'b0, 1'b1, 1'b1, {1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b1}};

    // reset idle
    do_reset();
    @(negedge clk);
    chk("idle_awvalid", awvalid, 0);
    chk("idle_wvalid", wvalid, 0);
    chk("idle_awready", {m0_awready, m1_awready}, 0);
    chk("idle_wready", {m0_wready, m1_wready}, 0);
    chk("idle_bvalid", {m0_bvalid, m1_bvalid}, 0);
    chk("idle_awid", awid, 0);

    // round-robin with both masters requesting
    @(posedge clk); #1;
    m0_awid = 3'h5; m0_awaddr = 32'h1000; m0_awvalid = 1;
    m1_awid = 3'h2; m1_awaddr = 32'h2000; m1_awvalid = 1;
    awready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_m0_awready", m0_awready, (i % 2 == 0));
      chk("rr_m1_awready", m1_awready, (i % 2 == 1));
      if (i > 0) chk("rr_awid", awid, (i % 2 == 1) ? 4'h5 : 4'hA);
      @(posedge clk); #1;
    end
    m0_awvalid = 0; m1_awvalid = 0;
    @(negedge clk);
    chk("rr_last_awid", awid, 4'hA);
    chk("rr_last_awaddr", awaddr, 32'h2000);
    chk("rr_last_awvalid", awvalid, 1);
    @(posedge clk); #1;
    m0_wdata = 16'hA0A0; m0_wlast = 1; m0_wvalid = 1;
    m1_wdata = 16'hB1B1; m1_wlast = 1; m1_wvalid = 1;
    wready = 1;
    @(negedge clk);
    chk("rr_awvalid_drain", awvalid, 0);
    exp_q = '{16'hA0A0, 16'hB1B1, 16'hA0A0, 16'hB1B1};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("rr_order_wvalid", wvalid, 1);
      chk("rr_order_wdata", wdata, exp_q.pop_front());
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rr_order_empty", wvalid, 0);

    // W ordering: m0 4-beat burst then m1 single beat
    do_reset();
    m0_awlen = 8'd3; m0_awvalid = 1; m1_awlen = 8'd0; m1_awvalid = 1; awready = 1;
    beat0 = 0;
    m0_wdata = 16'hA000; m0_wlast = 0; m0_wvalid = 1;
    m1_wdata = 16'hB000; m1_wlast = 1; m1_wvalid = 1;
    wready = 1;
    exp_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hB000};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("wo_stall_wvalid", wvalid, 0);
        chk("wo_stall_m0_wready", m0_wready, 0);
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) chk("wo_extra_beat", wdata, 16'hFFFF);
        else chk("wo_beat", wdata, exp_q.pop_front());
      end
      if (beat0 < 4 && i > 0) chk("wo_m1_wready", m1_wready, 0);
      hs0 = m0_wvalid && m0_wready;
      hs1 = m1_wvalid && m1_wready;
      @(posedge clk); #1;
      if (i == 0) m0_awvalid = 0;
      if (i == 1) m1_awvalid = 0;
      if (hs0) begin
        beat0++;
        m0_wdata = 16'hA000 + 16'(beat0);
        m0_wlast = (beat0 == 3);
        if (beat0 == 4) m0_wvalid = 0;
      end
      if (hs1) m1_wvalid = 0;
    end
    chk("wo_all_beats", exp_q.size(), 0);
    m0_wvalid = 1; m0_wlast = 1;
    @(negedge clk);
    chk("wo_fifo_empty", {wvalid, m0_wready, m1_wready}, 0);

    // B routing vector table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bid = bvecs[i].bid; bresp = bvecs[i].bresp; bvalid = bvecs[i].bvalid;
      m0_bready = bvecs[i].m0_bready; m1_bready = bvecs[i].m1_bready;
      #1;
      chk($sformatf("bvec%0d", i),
          {m0_bvalid, m0_bid, m0_bresp, m1_bvalid, m1_bid, m1_bresp, bready}, bvecs[i].exp);
    end
    // B held while m1 back-pressures
    @(posedge clk); #1;
    bid = 4'b1011; bresp = 2'd2; bvalid = 1; m0_bready = 1; m1_bready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m1_bready = 1;
      #1;
      chk("bhold_m1", {m1_bvalid, m1_bid, m1_bresp}, {1'b1, 3'b011, 2'd2});
      chk("bhold_bready", bready, (i == 2));
      chk("bhold_m0_bvalid", m0_bvalid, 0);
      @(posedge clk); #1;
    end
    bvalid = 0;

    // outstanding limit
    do_reset();
    m0_awid = 3'h1; m0_awaddr = 32'h3000; m0_awvalid = 1; awready = 1;
    for (int i = 0; i < MAXOUT; i++) begin
      @(negedge clk);
      chk("lim_grant", m0_awready, 1);
      @(posedge clk); #1;
    end
    m1_awid = 3'h7; m1_awvalid = 1;
    @(negedge clk);
    chk("lim_m0_stalled", m0_awready, 0);
    chk("lim_m1_granted", m1_awready, 1);
    @(posedge clk); #1;
    m1_awvalid = 0;
    bid = 4'b0001; bvalid = 1; m0_bready = 1;
    @(negedge clk);
    chk("lim_b_cycle", {m0_bvalid, m0_awready}, 2'b10);
    @(posedge clk); #1;
    bvalid = 0;
    @(negedge clk);
    chk("lim_regrant", m0_awready, 1);
    @(posedge clk); #1;
    m0_awvalid = 0;
    @(negedge clk);
    chk("lim_awid", {awvalid, awid}, {1'b1, 4'h1});

    // backpressure, order FIFO full, reset mid-burst
    do_reset();
    m0_awvalid = 1; m1_awvalid = 1; awready = 0;
    m0_wvalid = 1; m0_wlast = 1; m0_wdata = 16'hC000;
    m1_wvalid = 1; m1_wlast = 1; m1_wdata = 16'hD000;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0_awready || m1_awready) grants++;
      @(posedge clk); #1;
    end
    chk("bp_single_grant", grants, 1);
    awready = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m0_awready || m1_awready) grants++;
      @(posedge clk); #1;
    end
    chk("bp_grants_to_full", grants, 8);
    wready = 1;
    @(negedge clk);
    chk("bp_full_pop_wvalid", {wvalid, wdata}, {1'b1, 16'hC000});
    chk("bp_full_blocks", {m0_awready, m1_awready}, 0);
    @(posedge clk); #1;
    wready = 0;
    @(negedge clk);
    chk("bp_after_pop", {m0_awready, m1_awready}, 2'b10);
    @(posedge clk); #1;
    wready = 1;
    #1;
    chk("rst_pre_wvalid", wvalid, 1);
    rst_n = 0;
    #1;
    chk("rst_aw", {awvalid, awid, awaddr}, 0);
    chk("rst_w", {wvalid, wdata, m0_wready, m1_wready}, 0);
    do_reset();
    m0_awvalid = 1; awready = 1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0_awready) grants++;
      @(posedge clk); #1;
    end
    chk("rst_counter_cleared", grants, MAXOUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
